// File: rtl/cv32e40x_pma_obi_filter_pkg.sv
// PMA region descriptor type and the two default attribute sets used by the filter.
package cv32e40x_pma_obi_filter_pkg;

    typedef struct packed {
        logic [31:0] word_addr_low;
        logic [31:0] word_addr_high;
        logic        main;
        logic        bufferable;
        logic        cacheable;
        logic        atomic;
    } pma_cfg_t;

    // Unmatched address inside a configured map: I/O, no attributes
    localparam pma_cfg_t PMA_R_DEFAULT = '{
        word_addr_low: 32'h0, word_addr_high: 32'h0,
        main: 1'b0, bufferable: 1'b0, cacheable: 1'b0, atomic: 1'b0};

    // Deconfigured PMA: everything behaves as main memory
    localparam pma_cfg_t NO_PMA_R_DEFAULT = '{
        word_addr_low: 32'h0, word_addr_high: 32'h0,
        main: 1'b1, bufferable: 1'b0, cacheable: 1'b0, atomic: 1'b1};

endpackage

// File: rtl/cv32e40x_pma_obi_filter_if.sv
// Core-side request/response channel plus bus-side channel of the PMA OBI filter.
interface cv32e40x_pma_obi_filter_if;

    logic        core_req_i;
    logic        core_gnt_o;
    logic [31:0] core_addr_i;
    logic        core_atomic_i;
    logic        core_spec_i;
    logic        core_exec_i;
    logic        core_misaligned_i;
    logic        core_rvalid_o;
    logic        core_err_o;
    logic        core_bufferable_o;
    logic        core_cacheable_o;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic [31:0] bus_addr_o;
    logic        bus_rvalid_i;

    modport master (
        output core_req_i, core_addr_i, core_atomic_i, core_spec_i, core_exec_i,
               core_misaligned_i, bus_gnt_i, bus_rvalid_i,
        input  core_gnt_o, core_rvalid_o, core_err_o, core_bufferable_o,
               core_cacheable_o, bus_req_o, bus_addr_o
    );

    modport slave (
        input  core_req_i, core_addr_i, core_atomic_i, core_spec_i, core_exec_i,
               core_misaligned_i, bus_gnt_i, bus_rvalid_i,
        output core_gnt_o, core_rvalid_o, core_err_o, core_bufferable_o,
               core_cacheable_o, bus_req_o, bus_addr_o
    );

endinterface

// File: rtl/cv32e40x_pma_obi_filter.sv
// Sequential PMA filter: region lookup, bus forwarding, outstanding tracking, in-order local error responses.
// Optional error-address capture enabled by defining CV32E40X_PMA_ERR_CAPTURE_EN.
module cv32e40x_pma_obi_filter
    import cv32e40x_pma_obi_filter_pkg::*;
#(
    parameter int unsigned A_EXTENSION     = 0,
    parameter int unsigned PMA_NUM_REGIONS = 0,
    parameter pma_cfg_t    PMA_CFG [(PMA_NUM_REGIONS > 0 ? PMA_NUM_REGIONS : 1)-1:0] =
                               '{default: PMA_R_DEFAULT},
    parameter int unsigned PMA_ADDR_LSB    = 0,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    cv32e40x_pma_obi_filter_if.slave    obi
`ifdef CV32E40X_PMA_ERR_CAPTURE_EN
    ,
    output logic [31:0]                 err_addr_o,
    output logic                        err_valid_o,
    input  logic                        err_clear_i
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam pma_cfg_t    DFLT  = (PMA_NUM_REGIONS == 0) ? NO_PMA_R_DEFAULT : PMA_R_DEFAULT;

    typedef enum logic [1:0] {PASS, ERR_WAIT, ERR_RESP} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [31:0]        w_word_addr;
    logic               w_main;
    logic               w_bufferable;
    logic               w_cacheable;
    logic               w_atomic;
    logic               w_err;
    logic               w_inc;
    logic               w_dec;

    assign w_word_addr = {2'b00, obi.core_addr_i[31:2]};

    // Region lookup; walking downwards lets the lowest matching index win
    always_comb begin
        w_main       = DFLT.main;
        w_bufferable = DFLT.bufferable;
        w_cacheable  = DFLT.cacheable;
        w_atomic     = DFLT.atomic;
        for (int i = int'(PMA_NUM_REGIONS) - 1; i >= 0; i--) begin
            if (((w_word_addr >> PMA_ADDR_LSB) >= (PMA_CFG[i].word_addr_low  >> PMA_ADDR_LSB)) &&
                ((w_word_addr >> PMA_ADDR_LSB) <  (PMA_CFG[i].word_addr_high >> PMA_ADDR_LSB))) begin
                w_main       = PMA_CFG[i].main;
                w_bufferable = PMA_CFG[i].bufferable;
                w_cacheable  = PMA_CFG[i].cacheable;
                w_atomic     = PMA_CFG[i].atomic;
            end
        end
    end

    assign w_err = (obi.core_atomic_i && !((A_EXTENSION != 0) && w_atomic)) ||
                   ((obi.core_spec_i || obi.core_exec_i || obi.core_misaligned_i) && !w_main);

    assign obi.core_bufferable_o = w_bufferable;
    assign obi.core_cacheable_o  = w_cacheable;
    assign obi.bus_addr_o        = obi.core_addr_i;

    assign w_inc = obi.bus_req_o && obi.bus_gnt_i;
    assign w_dec = obi.bus_rvalid_i && (r_cnt != '0);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_inc && !w_dec) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end else if (!w_inc && w_dec) begin
            w_cnt_next = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PASS;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PASS: begin
                if (obi.core_req_i && w_err) begin
                    w_state_next = (w_cnt_next == '0) ? ERR_RESP : ERR_WAIT;
                end
            end
            ERR_WAIT: begin
                if (w_cnt_next == '0) begin
                    w_state_next = ERR_RESP;
                end
            end
            ERR_RESP: w_state_next = PASS;
            default:  w_state_next = PASS;
        endcase
    end

    // Faulting requests are accepted locally, independent of bus credit
    always_comb begin
        obi.core_gnt_o    = 1'b0;
        obi.bus_req_o     = 1'b0;
        obi.core_rvalid_o = obi.bus_rvalid_i;
        obi.core_err_o    = 1'b0;
        case (r_state)
            PASS: begin
                if (obi.core_req_i && w_err) begin
                    obi.core_gnt_o = 1'b1;
                end else begin
                    obi.bus_req_o  = obi.core_req_i && (r_cnt < CNT_W'(MAX_OUTSTANDING));
                    obi.core_gnt_o = obi.bus_req_o && obi.bus_gnt_i;
                end
            end
            ERR_RESP: begin
                obi.core_rvalid_o = 1'b1;
                obi.core_err_o    = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CV32E40X_PMA_ERR_CAPTURE_EN
    logic w_err_accept;
    assign w_err_accept = (r_state == PASS) && obi.core_req_i && w_err;

    // First faulting address is sticky until cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr_o  <= 32'h0;
            err_valid_o <= 1'b0;
        end else if (w_err_accept && !err_valid_o) begin
            err_addr_o  <= obi.core_addr_i;
            err_valid_o <= 1'b1;
        end else if (err_clear_i) begin
            err_valid_o <= 1'b0;
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
                                      !(obi.bus_rvalid_i && (r_cnt == '0)))
        else $error("bus_rvalid_i with no outstanding bus transaction");
`endif

endmodule

// File: doc/cv32e40x_pma_obi_filter.md
Name: cv32e40x_pma_obi_filter

Overview:
- Sequential successor to the combinational PMA check. It sits between a core-side OBI-style request channel (IF or LSU) and the bus.
- Performs a parametrised region lookup, forwards legal requests to the bus and tracks outstanding transactions.
- Illegal requests are never sent to the bus. The block returns a locally generated error response, in order, after all older bus responses have drained.

Parameters:
- A_EXTENSION, 0, enables the atomic attribute; when 0, every atomic access faults.
- PMA_NUM_REGIONS, 0, number of configured regions; 0 means PMA deconfigured, and NO_PMA_R_DEFAULT applies to all addresses.
- PMA_CFG, '{default:PMA_R_DEFAULT}, region array; word_addr_low inclusive, word_addr_high exclusive.
- PMA_ADDR_LSB, 0, lowest word-address bit compared; coarsens region granularity to 2^PMA_ADDR_LSB words.
- MAX_OUTSTANDING, 2, maximum bus transactions in flight (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- core_req_i  in  1  core request valid
- core_gnt_o  out  1  request accepted
- core_addr_i  in  32  byte address
- core_atomic_i  in  1  atomic access
- core_spec_i  in  1  speculative access
- core_exec_i  in  1  instruction fetch
- core_misaligned_i  in  1  part of a misaligned split
- core_rvalid_o  out  1  response valid
- core_err_o  out  1  PMA error response (qualified by core_rvalid_o)
- core_bufferable_o  out  1  attribute of current request
- core_cacheable_o  out  1  attribute of current request
- bus_req_o  out  1  bus request
- bus_gnt_i  in  1  bus grant
- bus_addr_o  out  32  equals core_addr_i
- bus_rvalid_i  in  1  bus response

Behaviour:
- Lookup (combinational):
  - word_addr = {2'b00, core_addr_i[31:2]}.
  - Region i matches when word_addr[31:PMA_ADDR_LSB] lies in [low, high), both bounds compared on the same bits.
  - The lowest matching index wins. If nothing matches, PMA_R_DEFAULT applies. A region with low>=high never matches.
- Error rules; err is the OR of:
  - core_atomic_i && !(A_EXTENSION && cfg.atomic)
  - (core_spec_i | core_exec_i | core_misaligned_i) && !cfg.main
- Attributes: core_bufferable_o and core_cacheable_o equal cfg.bufferable and cfg.cacheable of the current address. They are combinational and valid whenever core_req_i=1.
- Counter cnt, width $clog2(MAX_OUTSTANDING+1), reset 0:
  - +1 on bus_req_o&&bus_gnt_i; -1 on bus_rvalid_i; both in one cycle leaves cnt unchanged.
  - bus_rvalid_i with cnt=0 is ignored (no underflow; flagged by assertion).
- FSM states PASS, ERR_WAIT, ERR_RESP; reset state is PASS.
- PASS:
  - No err: bus_req_o = core_req_i && (cnt<MAX_OUTSTANDING); core_gnt_o = bus_req_o && bus_gnt_i; core_rvalid_o = bus_rvalid_i; core_err_o = 0.
  - core_req_i && err: bus_req_o=0, core_gnt_o=1 (accepted regardless of cnt). Next state is ERR_RESP if cnt_next==0, else ERR_WAIT.
- ERR_WAIT:
  - core_gnt_o=0, bus_req_o=0; bus responses are forwarded with core_err_o=0.
  - Go to ERR_RESP when cnt_next==0.
- ERR_RESP:
  - core_rvalid_o=1, core_err_o=1 for exactly one cycle; core_gnt_o=0, bus_req_o=0; then PASS.
  - bus_rvalid_i cannot occur here because cnt=0.
- Latency:
  - Legal request: zero added latency (bus_req_o is combinational from core_req_i).
  - Error request accepted in cycle N with cnt=0: error response in N+1.
  - Otherwise: error response one cycle after the last older bus response.
- Reset outputs: core_gnt_o=0, core_rvalid_o=0, core_err_o=0, bus_req_o=0 (with core_req_i low).
- Reset mid-operation: cnt=0, state PASS; any pending error response is dropped.
- Ordering: responses to the core are strictly in request order.

Optional Feature:
- CV32E40X_PMA_ERR_CAPTURE_EN adds three ports:
  - err_addr_o  out  32
  - err_valid_o  out  1
  - err_clear_i  in  1
- With the macro defined:
  - On the first accepted error request while err_valid_o=0, core_addr_i is registered into err_addr_o and err_valid_o is set (sticky).
  - Later errors do not overwrite the captured address.
  - err_clear_i clears err_valid_o next cycle. If a capture and a clear occur in the same cycle, the capture wins.
  - Reset: err_addr_o=0, err_valid_o=0.
- Without the macro: the ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Regions {0x100-0x200 main, 0x200-0x300 I/O}; exec fetch at byte 0x0400 (word 0x100), bus_gnt_i=1 -> bus_req_o=1, core_gnt_o=1 same cycle, cnt=1, core_err_o=0 on response.
- Exec fetch at byte 0x0800 (word 0x200, I/O) with cnt=0 -> bus_req_o stays 0, core_gnt_o=1; core_rvalid_o=1 and core_err_o=1 next cycle.
- Two legal requests outstanding (cnt=2), then an error request -> no further grants; the two bus responses pass through with core_err_o=0; error response arrives one cycle after the 2nd response.
- MAX_OUTSTANDING=2, cnt=2, legal request -> bus_req_o=0. bus_rvalid_i -> cnt=1, bus_req_o=1 next cycle. Simultaneous gnt+rvalid -> cnt unchanged.
- A_EXTENSION=0, atomic to a main region -> error. Overlapping regions 0 and 1 -> region 0 attributes win. Address equal to high bound -> no match, default applies.
- Reset asserted in ERR_WAIT -> outputs 0, state PASS, no error response. With CV32E40X_PMA_ERR_CAPTURE_EN: two errors at 0x0800 then 0x0900 -> err_addr_o=0x0800; err_clear_i -> err_valid_o=0.
